// File: rtl/ghostbus_arbiter_if.sv
// Ghostbus arbiter port bundle: two requester channels plus the shared gb_* host bus.
// The master view is the arbiter; the slave view is the requesters and the ghostbus top together.
interface ghostbus_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          rq0_req;
  logic          rq0_we;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic          rq0_ack;
  logic [DW-1:0] rq0_rdata;

  logic          rq1_req;
  logic          rq1_we;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic          rq1_ack;
  logic [DW-1:0] rq1_rdata;

  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wen;
  logic          gb_rstb;
  logic [DW-1:0] gb_rdata;

  // Handshake: rqN_req is held high with stable fields until the one-cycle
  // rqN_ack; the requester drops req on the edge where it samples ack.
  modport master (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  gb_rdata,
    output rq0_ack, rq0_rdata, rq1_ack, rq1_rdata,
    output gb_addr, gb_wdata, gb_wen, gb_rstb
  );

  modport slave (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output gb_rdata,
    input  rq0_ack, rq0_rdata, rq1_ack, rq1_rdata,
    input  gb_addr, gb_wdata, gb_wen, gb_rstb
  );
endinterface

// File: rtl/ghostbus_arbiter.sv
// Two-requester arbiter sharing one ghostbus host port, one transaction at a time.
// Define GHOSTBUS_ARB_FIXED_PRIO_EN for fixed rq0 priority; default is round-robin.
// dbg_state encoding: 0 IDLE, 1 STROBE, 2 WAIT, 3 CAPTURE, 4 ACK.
module ghostbus_arbiter #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic               gb_clk,
  input  logic               gb_rst_n,
  ghostbus_arbiter_if.master bus,
  output logic [2:0]         dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STROBE  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          grant, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          any_req;
  logic          win;

  assign any_req = bus.rq0_req | bus.rq1_req;

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
  assign win = ~bus.rq0_req;
`else
  logic last;

  // Under contention the requester not served last wins; a lone requester always wins.
  assign win = (bus.rq0_req & bus.rq1_req) ? ~last : bus.rq1_req;

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n)                     last <= 1'b1;
    else if (state == S_IDLE && any_req) last <= win;
  end
`endif

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state   <= S_IDLE;
      grant   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_d = win;
          we_d    = win ? bus.rq1_we    : bus.rq0_we;
          addr_d  = win ? bus.rq1_addr  : bus.rq0_addr;
          wdata_d = win ? bus.rq1_wdata : bus.rq0_wdata;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else if (RD_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = 4'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter reaching zero on this edge means gb_rdata is valid next cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == S_CAPTURE) begin
      if (grant) rdata1_q <= bus.gb_rdata;
      else       rdata0_q <= bus.gb_rdata;
    end
  end

  assign bus.gb_addr   = addr_q;
  assign bus.gb_wdata  = wdata_q;
  assign bus.gb_wen    = (state == S_STROBE) &  we_q;
  assign bus.gb_rstb   = (state == S_STROBE) & ~we_q;
  assign bus.rq0_ack   = (state == S_ACK) & ~grant;
  assign bus.rq1_ack   = (state == S_ACK) &  grant;
  assign bus.rq0_rdata = rdata0_q;
  assign bus.rq1_rdata = rdata1_q;
  assign dbg_state     = state;
endmodule

// File: doc/ghostbus_arbiter.md
# ghostbus_arbiter

Two-requester arbiter that shares one ghostbus host port (the `gb_*` bus into a ghostbus-generated top) between two independent bus masters, e.g. a host interface and an on-chip sequencer. It runs one transaction at a time, generates the single-cycle `gb_wen`/`gb_rstb` strobes and waits a fixed read latency before capturing `gb_rdata`. It returns data and a one-cycle acknowledge to the winning requester.

## Interface
- `AW`, 24, address width of the ghostbus and requester addresses
- `DW`, 32, data width
- `RD_LAT`, 2, cycles from the `gb_rstb` cycle to the cycle `gb_rdata` is valid; legal range 1..15
- `gb_clk`  in  1  bus clock; all logic is on its rising edge
- `gb_rst_n`  in  1  asynchronous, active-low reset
- `rq0_req`, `rq1_req`  in  1  transaction request, held high until ack
- `rq0_we`, `rq1_we`  in  1  1 = write, 0 = read
- `rq0_addr`, `rq1_addr`  in  AW  transaction address
- `rq0_wdata`, `rq1_wdata`  in  DW  write data
- `rq0_ack`, `rq1_ack`  out  1  one-cycle completion pulse
- `rq0_rdata`, `rq1_rdata`  out  DW  read data, valid in the ack cycle and held until the next read ack to that requester
- `gb_addr`  out  AW  bus address
- `gb_wdata`  out  DW  bus write data
- `gb_wen`  out  1  write strobe (also drives the wstb alias)
- `gb_rstb`  out  1  read strobe
- `gb_rdata`  in  DW  bus read data

## Operation
- **FSM states:**
  - IDLE: sample `rqN_req`. If any is high, latch the winner's `we/addr/wdata` into bus registers, record the grant, and go to STROBE.
  - STROBE: `gb_wen = we` or `gb_rstb = ~we` for exactly one cycle. Writes go to ACK. Reads load the latency counter with `RD_LAT-1` and go to WAIT; if `RD_LAT=1`, go straight to CAPTURE.
  - WAIT: decrement the counter and go to CAPTURE at 0.
  - CAPTURE: register `gb_rdata` into the granted requester's `rqN_rdata`, then go to ACK.
  - ACK: pulse `rqN_ack` for the granted requester, then go to IDLE.
- **Arbitration:** round-robin. A `last` pointer records the last requester served. When both requesters are high in IDLE, the one not equal to `last` wins. A lone requester always wins.
- **Request fields:** latched at grant. Changes while the transaction is pending are ignored.
- **Bus idle values:** `gb_addr`/`gb_wdata` hold their last values; `gb_wen` and `gb_rstb` are 0. `gb_addr` is stable from the STROBE cycle through CAPTURE.
- **Loser's request:** stays pending and is served at the next IDLE; it is never dropped.
- **Width rules:** the latency counter is 4 bits. `rqN_rdata` is the full `DW`, with no masking.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last` = 1 (so rq0 wins the first contention).
- **Reset mid-operation:** the transaction is abandoned with no ack and no further strobe. The requester must re-request.
- **Write:** request seen in IDLE cycle T. `gb_wen` high in T+1. Ack in T+2. Latency from request to ack is 2 cycles.
- **Read:** `gb_rstb` high in cycle T+1. `gb_rdata` is sampled at the end of cycle T+1+RD_LAT. Ack and `rqN_rdata` are valid in T+2+RD_LAT.
- **Requester handshake:** the requester drops `req` on the edge where it sees ack. A new request from the same requester (or the other one) is granted in cycle ack+1 at the earliest.
- **Bus occupancy:** at most one strobe is outstanding, so there is no overlap of `gb_wen` and `gb_rstb`.
- **Throughput:** back-to-back writes complete one per 3 cycles. Reads complete one per RD_LAT+3 cycles.
- **Simultaneous events:** both requesters rising in the same IDLE cycle is resolved by `last`. A request arriving during another's ACK cycle is granted in the following IDLE.

## Configuration
- `GHOSTBUS_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. rq0 always wins contention and `last` is unused. rq1 may starve while rq0 streams requests.
  - Undefined (default): round-robin as described above.

## Test plan
- **Reset values:** hold `gb_rst_n`=0 then release -> all outputs 0. rq0 write to 0x000000 with 0x42 -> `gb_wen`=1 for one cycle with `gb_addr`=0x000000 and `gb_wdata`=0x42; `rq0_ack` 2 cycles after req.
- **Read latency:** RD_LAT=2; rq1 read of 0x000004; bench drives `gb_rdata`=0x0000000c two cycles after `gb_rstb` -> `rq1_rdata`=0x0000000c with `rq1_ack` 4 cycles after req, and `gb_addr` stable throughout.
- **Contention:** rq0 and rq1 raise `req` in the same cycle, each with 3 back-to-back writes -> grants alternate rq0, rq1, rq0, rq1, rq0, rq1. With `GHOSTBUS_ARB_FIXED_PRIO_EN` defined -> rq0 ×3 then rq1 ×3.
- **Field latching:** change `rq0_addr` from 0x000100 to 0x000200 after grant -> the bus still shows 0x000100 and the new address is not used.
- **Reset mid-read:** assert `gb_rst_n`=0 during WAIT -> no ack, strobes 0. After release, a new rq1 read completes normally.
- **RD_LAT=1 boundary:** ack 3 cycles after req; `gb_rdata` is sampled in the cycle immediately after `gb_rstb`.
